// File: rtl/alu_exec_seq_if.sv
// Request/response bundle for the EX-stage ALU.
// master drives operands and consumes results; slave is the ALU.
interface alu_exec_seq_if #(
    parameter int WIDTH = 32
) ();
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [2:0]       alu_op;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [SHW-1:0]   shamt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic [3:0]       alu_ctl;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, alu_op, func, a, b, shamt, out_ready,
        input  in_ready, out_valid, result, result_hi,
        input  alu_ctl, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, alu_op, func, a, b, shamt, out_ready,
        output in_ready, out_valid, result, result_hi,
        output alu_ctl, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_exec_seq.sv
// Registered EX-stage ALU with decode, flags and an iterative
// shift-add multiplier behind a valid/ready handshake.
module alu_exec_seq #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    alu_exec_seq_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_XOR = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_SLL = 4'b1000;
    localparam logic [3:0] C_SRL = 4'b1001;
    localparam logic [3:0] C_SRA = 4'b1010;
    localparam logic [3:0] C_MUL = 4'b1011;
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_ILL = 4'b1111;

    logic [0:0]       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [3:0]       alu_ctl_q, alu_ctl_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    logic             in_ready;
    logic             accept;
    logic [3:0]       ctl;
    logic [WIDTH-1:0] res;
    logic             ovf_c;
    logic [WIDTH:0]   msum;
    logic             sa, sb, sr;

    assign in_ready = !rst && (state_q == S_IDLE)
                      && (!out_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        ctl = C_ILL;
        case (bus.alu_op)
            3'b000, 3'b011: ctl = C_ADD;
            3'b001:         ctl = C_SUB;
            3'b100:         ctl = C_OR;
            3'b101:         ctl = C_AND;
            3'b110:         ctl = C_SLT;
            3'b010: begin
                case (bus.func)
                    6'b100000: ctl = C_ADD;
                    6'b100010: ctl = C_SUB;
                    6'b100100: ctl = C_AND;
                    6'b100101: ctl = C_OR;
                    6'b101010: ctl = C_SLT;
                    6'b100111: ctl = C_NOR;
                    6'b100110: ctl = C_XOR;
                    6'b000000: ctl = C_SLL;
                    6'b000010: ctl = C_SRL;
                    6'b000011: ctl = C_SRA;
                    6'b011000: ctl = MUL_EN ? C_MUL : C_ILL;
                    default:   ctl = C_ILL;
                endcase
            end
            default: ctl = C_ILL;
        endcase
    end

    always_comb begin
        res = '0;
        case (ctl)
            C_ADD: res = bus.a + bus.b;
            C_SUB: res = bus.a - bus.b;
            C_AND: res = bus.a & bus.b;
            C_OR:  res = bus.a | bus.b;
            C_XOR: res = bus.a ^ bus.b;
            C_NOR: res = ~(bus.a | bus.b);
            C_SLT: res = {{(WIDTH-1){1'b0}},
                          $signed(bus.a) < $signed(bus.b)};
            C_SLL: res = bus.a << bus.shamt;
            C_SRL: res = bus.a >> bus.shamt;
            C_SRA: res = $unsigned($signed(bus.a) >>> bus.shamt);
            default: res = '0;
        endcase
        sa = bus.a[WIDTH-1];
        sb = bus.b[WIDTH-1];
        sr = res[WIDTH-1];
        ovf_c = 1'b0;
        if (ctl == C_ADD) ovf_c = (sa == sb) && (sr != sa);
        if (ctl == C_SUB) ovf_c = (sa != sb) && (sr != sa);
    end

    // Partial product lives in {result_hi_q, result_q}; multiplier bits shift out of result_q.
    assign msum = {1'b0, result_hi_q}
                  + (result_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        alu_ctl_d   = alu_ctl_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        cnt_d       = cnt_q;
        case (state_q)
            S_MUL: begin
                result_hi_d = msum[WIDTH:1];
                result_d    = {msum[0], result_q[WIDTH-1:1]};
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b1;
                    alu_ctl_d   = C_MUL;
                    zero_d      = (result_d == '0);
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                end
            end
            default: begin
                if (accept && ctl == C_MUL) begin
                    state_d     = S_MUL;
                    out_valid_d = 1'b0;
                    mcand_d     = bus.a;
                    result_d    = bus.b;
                    result_hi_d = '0;
                    cnt_d       = '0;
                end else if (accept) begin
                    out_valid_d = 1'b1;
                    result_d    = res;
                    result_hi_d = '0;
                    alu_ctl_d   = ctl;
                    zero_d      = (res == '0);
                    ovf_d       = ovf_c;
                    illegal_d   = (ctl == C_ILL);
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            alu_ctl_q   <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            alu_ctl_q   <= alu_ctl_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.alu_ctl   = alu_ctl_q;
    assign bus.zero      = zero_q;
    assign bus.ovf       = ovf_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq: decode, flags, MULT timing,
// back-pressure and reset during a multiply.
module tb_alu_exec_seq;
    logic clk;
    logic rst;
    int   tests;
    int   fails;
    int   n;
    bit   seen_ready;

    alu_exec_seq_if #(.WIDTH(32)) bus ();

    alu_exec_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input string tag,
                         input logic [2:0] op,
                         input logic [5:0] fn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] sh);
        bus.in_valid = 1'b1;
        bus.alu_op   = op;
        bus.func     = fn;
        bus.a        = a;
        bus.b        = b;
        bus.shamt    = sh;
        #1;
        chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.alu_op    = '0;
        bus.func      = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.shamt     = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_res",   64'(bus.result), 64'd0);
        chk("rst_hi",    64'(bus.result_hi), 64'd0);
        chk("rst_ctl",   64'(bus.alu_ctl), 64'd0);
        chk("rst_flags", 64'({bus.zero, bus.ovf, bus.illegal}), 64'd0);
        chk("rst_rdy",   64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rel_rdy", 64'(bus.in_ready), 64'd1);

        issue("add", 3'b010, 6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd0);
        chk("add_valid", 64'(bus.out_valid), 64'd1);
        chk("add_res",   64'(bus.result), 64'h8000_0000);
        chk("add_ovf",   64'(bus.ovf), 64'd1);
        chk("add_ctl",   64'(bus.alu_ctl), 64'h2);
        chk("add_zero",  64'(bus.zero), 64'd0);
        chk("add_hi",    64'(bus.result_hi), 64'd0);

        issue("beq", 3'b001, 6'b0, 32'h1234, 32'h1234, 5'd0);
        chk("beq_res",  64'(bus.result), 64'd0);
        chk("beq_zero", 64'(bus.zero), 64'd1);
        chk("beq_ctl",  64'(bus.alu_ctl), 64'h6);
        chk("beq_ovf",  64'(bus.ovf), 64'd0);

        issue("slti", 3'b110, 6'b0, 32'hFFFF_FFFF, 32'd0, 5'd0);
        chk("slti_res", 64'(bus.result), 64'd1);
        chk("slti_ctl", 64'(bus.alu_ctl), 64'h7);

        issue("sub", 3'b010, 6'b100010, 32'h8000_0000, 32'd1, 5'd0);
        chk("sub_res", 64'(bus.result), 64'h7FFF_FFFF);
        chk("sub_ovf", 64'(bus.ovf), 64'd1);

        issue("ori", 3'b100, 6'b0, 32'hF0, 32'h0F, 5'd0);
        chk("ori_res", 64'({bus.alu_ctl, bus.result}), {4'h1, 32'hFF});
        issue("andr", 3'b010, 6'b100100, 32'hFF00, 32'h0FF0, 5'd0);
        chk("and_res", 64'({bus.alu_ctl, bus.result}), {4'h0, 32'h0F00});
        issue("nor", 3'b010, 6'b100111, 32'h0, 32'hFFFF_0000, 5'd0);
        chk("nor_res", 64'({bus.alu_ctl, bus.result}), {4'hC, 32'h0000_FFFF});
        issue("xor", 3'b010, 6'b100110, 32'hFF, 32'h0F, 5'd0);
        chk("xor_res", 64'({bus.alu_ctl, bus.result}), {4'h3, 32'hF0});
        issue("sll", 3'b010, 6'b000000, 32'd1, 32'hFFFF, 5'd31);
        chk("sll_res", 64'({bus.alu_ctl, bus.result}), {4'h8, 32'h8000_0000});
        issue("slt", 3'b010, 6'b101010, 32'd5, 32'hFFFF_FFFD, 5'd0);
        chk("slt_res", 64'({bus.alu_ctl, bus.result}), {4'h7, 32'h0});

        issue("sra", 3'b010, 6'b000011, 32'h8000_0000, 32'd0, 5'd4);
        chk("sra_res", 64'({bus.alu_ctl, bus.result}), {4'hA, 32'hF800_0000});
        issue("srl", 3'b010, 6'b000010, 32'h8000_0000, 32'd0, 5'd4);
        chk("srl_res", 64'({bus.alu_ctl, bus.result}), {4'h9, 32'h0800_0000});
        issue("ill", 3'b010, 6'b111111, 32'h55, 32'h66, 5'd0);
        chk("ill_flag", 64'(bus.illegal), 64'd1);
        chk("ill_res",  64'(bus.result), 64'd0);
        chk("ill_ctl",  64'(bus.alu_ctl), 64'hF);
        chk("ill_ovf",  64'(bus.ovf), 64'd0);
        issue("op7", 3'b111, 6'b100000, 32'h1, 32'h1, 5'd0);
        chk("op7_ill", 64'({bus.illegal, bus.alu_ctl}), {1'b1, 4'hF});

        issue("mul", 3'b010, 6'b011000, 32'hFFFF_FFFF, 32'd2, 5'd0);
        n = 1;
        seen_ready = 1'b0;
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) seen_ready = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        chk("mul_lat",  64'(n), 64'd33);
        chk("mul_rdy",  64'(seen_ready), 64'd0);
        chk("mul_hi",   64'(bus.result_hi), 64'd1);
        chk("mul_lo",   64'(bus.result), 64'hFFFF_FFFE);
        chk("mul_ctl",  64'(bus.alu_ctl), 64'hB);
        chk("mul_flag", 64'({bus.ovf, bus.illegal, bus.zero}), 64'd0);

        issue("mul2", 3'b010, 6'b011000, 32'h0001_0000, 32'h0001_0000, 5'd0);
        repeat (32) @(posedge clk);
        #1;
        chk("mul2_valid", 64'(bus.out_valid), 64'd1);
        chk("mul2_prod",  64'({bus.result_hi, bus.result}), 64'h1_0000_0000);
        chk("mul2_zero",  64'(bus.zero), 64'd1);

        issue("s0", 3'b011, 6'b0, 32'h10, 32'd1, 5'd0);
        chk("s0_res", 64'(bus.result), 64'h11);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.alu_op    = 3'b011;
        bus.a         = 32'h20;
        bus.b         = 32'd1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("stall_rdy", 64'(bus.in_ready), 64'd0);
            @(posedge clk);
            #1;
            chk("stall_hold", 64'({bus.out_valid, bus.result}), {1'b1, 32'h11});
        end
        bus.out_ready = 1'b1;
        issue("s1", 3'b011, 6'b0, 32'h20, 32'd1, 5'd0);
        chk("s1_res", 64'({bus.out_valid, bus.result}), {1'b1, 32'h21});
        issue("s2", 3'b011, 6'b0, 32'h30, 32'd1, 5'd0);
        chk("s2_res", 64'({bus.out_valid, bus.result}), {1'b1, 32'h31});
        issue("s3", 3'b011, 6'b0, 32'h40, 32'd1, 5'd0);
        chk("s3_res", 64'({bus.out_valid, bus.result}), {1'b1, 32'h41});
        @(posedge clk);
        #1;
        chk("drain_valid", 64'(bus.out_valid), 64'd0);

        issue("mrst", 3'b010, 6'b011000, 32'h1234, 32'h5678, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mrst_valid", 64'(bus.out_valid), 64'd0);
        chk("mrst_rdy0",  64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_rdy1", 64'(bus.in_ready), 64'd1);
        seen_ready = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen_ready = 1'b1;
            @(posedge clk);
            #1;
        end
        chk("mrst_noout", 64'(seen_ready), 64'd0);
        issue("post", 3'b000, 6'b0, 32'd3, 32'd4, 5'd0);
        chk("post_res", 64'({bus.alu_ctl, bus.result}), {4'h2, 32'd7});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
